// File: rtl/phase_sync.sv
// phase_sync
// Reference-edge aligner feeding the clock divider's phase_rst input.
// An asynchronous reference is synchronised and its rising edges detected.
// The interval between edges is measured in clk cycles. A lock state machine
// qualifies each edge, and only qualified edges pulse phase_rst. The divided
// clock therefore follows a stable reference and ignores glitches and missing
// edges.
//
// Parameters
//   PERIOD      expected reference period in clk cycles (divider cnt_max)
//   TOL         accepted interval error, good when PERIOD-TOL..PERIOD+TOL
//   LOCK_CNT    consecutive good intervals needed to lock
//   UNLOCK_CNT  consecutive bad or missing edges that drop lock
//
// Ports
//   clk        in   system clock, shared with the divider
//   rst_n      in   asynchronous active-low reset
//   ref_in     in   external reference, asynchronous to clk
//   enable     in   level, 0 forces IDLE
//   phase_rst  out  registered one-cycle pulse per qualified edge
//   locked     out  registered, high only while in LOCKED
//   period     out  last measured interval in clk cycles
//   miss       out  registered one-cycle pulse on an edge timeout
module phase_sync #(
  parameter logic [31:0] PERIOD     = 32'd1000,
  parameter logic [31:0] TOL        = 32'd4,
  parameter logic [7:0]  LOCK_CNT   = 8'd4,
  parameter logic [7:0]  UNLOCK_CNT = 8'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ref_in,
  input  logic        enable,
  output logic        phase_rst,
  output logic        locked,
  output logic [31:0] period,
  output logic        miss
);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;

  // Acceptance window, widened to 33 bits so PERIOD+TOL cannot wrap and
  // PERIOD-TOL clamps at zero instead of underflowing.
  localparam logic [32:0] HI = {1'b0, PERIOD} + {1'b0, TOL};
  localparam logic [32:0] LO = (PERIOD >= TOL) ? {1'b0, PERIOD - TOL} : 33'd0;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        s3;
  logic [31:0] per_cnt;
  logic [7:0]  good_cnt;
  logic [7:0]  bad_cnt;
  logic [7:0]  good_inc;
  logic [7:0]  bad_inc;
  logic [32:0] interval;
  logic        rise;
  logic        good;
  logic        timeout;

  // Two-flop synchroniser plus a history flop for edge detection. ref_in is
  // consumed nowhere else, so every downstream decision sees a clean level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ref_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign interval = {1'b0, per_cnt};
  assign good     = (interval >= LO) && (interval <= HI);
  assign good_inc = good_cnt + 8'd1;
  assign bad_inc  = bad_cnt + 8'd1;

  // Equality-only compare makes the timeout fire once per gap. A rise in
  // the same cycle wins and is judged as a (good) edge instead.
  assign timeout = ((state == TRACK) || (state == LOCKED)) &&
                   (interval == HI) && !rise;

  // Lock state machine with the interval counter and all registered
  // outputs. Pulses default low each cycle. Dropping enable overrides
  // everything, including a rise in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      per_cnt   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      phase_rst <= 1'b0;
      locked    <= 1'b0;
      period    <= '0;
      miss      <= 1'b0;
    end else begin
      phase_rst <= 1'b0;
      miss      <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        per_cnt  <= '0;
        good_cnt <= '0;
        bad_cnt  <= '0;
        locked   <= 1'b0;
      end else begin
        // Interval counter: restarts at 1 on an edge, saturates otherwise.
        if (state == IDLE) begin
          per_cnt <= '0;
        end else if (rise) begin
          per_cnt <= 32'd1;
        end else if (per_cnt != '1) begin
          per_cnt <= per_cnt + 32'd1;
        end

        // Every edge outside IDLE reports its interval, even in ACQ.
        if ((state != IDLE) && rise) begin
          period <= per_cnt;
        end

        case (state)
          IDLE: begin
            state  <= ACQ;
            locked <= 1'b0;
          end

          // The first edge only anchors the phase; its interval is unjudged.
          ACQ: begin
            if (rise) begin
              state     <= TRACK;
              good_cnt  <= '0;
              phase_rst <= 1'b1;
            end
          end

          // Every edge re-anchors the divider; bad ones restart the count.
          TRACK: begin
            if (rise) begin
              phase_rst <= 1'b1;
              if (good) begin
                good_cnt <= good_inc;
                if (good_inc == LOCK_CNT) begin
                  state   <= LOCKED;
                  bad_cnt <= '0;
                  locked  <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end else if (timeout) begin
              miss  <= 1'b1;
              state <= ACQ;
            end
          end

          // Only good edges re-anchor; bad or missing ones accumulate.
          LOCKED: begin
            if (rise && good) begin
              bad_cnt   <= '0;
              phase_rst <= 1'b1;
            end else if (rise || timeout) begin
              miss    <= timeout;
              bad_cnt <= bad_inc;
              if (bad_inc == UNLOCK_CNT) begin
                state  <= ACQ;
                locked <= 1'b0;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sync.sv
// tb_phase_sync
// Scoreboard bench for phase_sync. The stimulus side schedules reference
// edges by cycle number. Before driving each one, it runs an event-level
// reference model that walks the edge list with the lock rules and pushes
// the expected phase_rst, miss, locked and period events, tagged with the
// cycle in which they must be visible. A monitor on the falling edge pops
// and compares whenever the DUT presents an output.
module tb_phase_sync;

  localparam int PERIOD_C = 1000;
  localparam int TOL_C    = 4;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int HI       = PERIOD_C + TOL_C;
  localparam int LO       = (PERIOD_C >= TOL_C) ? PERIOD_C - TOL_C : 0;

  typedef struct {
    int tag;
    int val;
  } exp_t;

  typedef enum {M_IDLE, M_ACQ, M_TRACK, M_LOCKED} mode_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ref_in;
  logic        enable;
  logic        phase_rst;
  logic        locked;
  logic [31:0] period;
  logic        miss;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_c;
  exp_t  phase_q[$];
  exp_t  miss_q[$];
  exp_t  lock_q[$];
  exp_t  period_q[$];
  exp_t  mon_e;
  logic  prev_locked = 1'b0;

  mode_t m_mode   = M_IDLE;
  int    m_anchor = 0;
  int    m_good   = 0;
  int    m_bad    = 0;
  bit    m_locked = 1'b0;

  phase_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_in    (ref_in),
    .enable    (enable),
    .phase_rst (phase_rst),
    .locked    (locked),
    .period    (period),
    .miss      (miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  // A gap longer than PERIOD+TOL in TRACK/LOCKED produces one timeout,
  // visible PERIOD+TOL+1 cycles after the last counted edge.
  task automatic modelGap(input int r);
    exp_t x;
    if ((m_mode == M_TRACK || m_mode == M_LOCKED) && (r - m_anchor) > HI) begin
      x.tag = m_anchor + HI + 1;
      x.val = 1;
      miss_q.push_back(x);
      if (m_mode == M_TRACK) begin
        m_mode = M_ACQ;
      end else begin
        m_bad++;
        if (m_bad == UNLOCK_N) begin
          m_mode   = M_ACQ;
          m_locked = 1'b0;
          x.val    = 0;
          lock_q.push_back(x);
        end
      end
    end
  endtask

  // One edge whose synchronised rise falls in cycle r; results appear at r+1.
  task automatic modelRise(input int r, input bit discard);
    exp_t x;
    int   iv;
    bit   ok;
    modelGap(r);
    x.tag = r + 1;
    if (discard) begin
      if (m_locked) begin
        x.val = 0;
        lock_q.push_back(x);
      end
      m_locked = 1'b0;
      m_mode   = M_IDLE;
      m_good   = 0;
      m_bad    = 0;
    end else begin
      iv       = r - m_anchor;
      m_anchor = r;
      ok       = (iv >= LO) && (iv <= HI);
      x.val    = iv;
      period_q.push_back(x);
      x.val = 1;
      case (m_mode)
        M_ACQ: begin
          m_mode = M_TRACK;
          m_good = 0;
          phase_q.push_back(x);
        end
        M_TRACK: begin
          phase_q.push_back(x);
          if (ok) begin
            m_good++;
            if (m_good == LOCK_N) begin
              m_mode   = M_LOCKED;
              m_bad    = 0;
              m_locked = 1'b1;
              lock_q.push_back(x);
            end
          end else begin
            m_good = 0;
          end
        end
        M_LOCKED: begin
          if (ok) begin
            m_bad = 0;
            phase_q.push_back(x);
          end else begin
            m_bad++;
            if (m_bad == UNLOCK_N) begin
              m_mode   = M_ACQ;
              m_locked = 1'b0;
              x.val    = 0;
              lock_q.push_back(x);
            end
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  // Drives a reference edge gap cycles after the previous one. The rise
  // reaches the state machine two cycles after the drive. drop_enable
  // lowers enable exactly in that rise cycle.
  task automatic applyStimulus(input int gap, input bit glitch, input bit drop_enable);
    int target;
    int hold;
    target = last_c + gap;
    hold   = glitch ? 1 : 20;
    modelRise(target + 2, drop_enable);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    ref_in = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (drop_enable && cyc == target + 2) enable = 1'b0;
    end
    ref_in = 1'b0;
    last_c = target;
  endtask

  task automatic reEnable(input int wait_cycles);
    repeat (wait_cycles) @(posedge clk);
    #1;
    enable   = 1'b1;
    m_mode   = M_ACQ;
    m_anchor = cyc + 1;
  endtask

  task automatic doReset();
    repeat (200) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_phase_rst", int'(phase_rst), 0);
    checkOutput("reset_mid_locked", int'(locked), 0);
    checkOutput("reset_mid_period", int'(period), 0);
    checkOutput("reset_mid_miss", int'(miss), 0);
    phase_q.delete();
    miss_q.delete();
    lock_q.delete();
    period_q.delete();
    m_mode   = M_IDLE;
    m_locked = 1'b0;
    m_good   = 0;
    m_bad    = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_mode   = M_ACQ;
    m_anchor = cyc + 1;
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_locked = 1'b0;
    end else begin
      while (phase_q.size() > 0 && phase_q[0].tag < cyc) begin
        mon_e = phase_q.pop_front();
        checkOutput("phase_rst_missing", 0, 1);
      end
      if (phase_rst) begin
        if (phase_q.size() == 0) begin
          checkOutput("phase_rst_unexpected", 1, 0);
        end else begin
          mon_e = phase_q.pop_front();
          checkOutput("phase_rst_cycle", cyc, mon_e.tag);
        end
      end
      while (miss_q.size() > 0 && miss_q[0].tag < cyc) begin
        mon_e = miss_q.pop_front();
        checkOutput("miss_missing", 0, 1);
      end
      if (miss) begin
        if (miss_q.size() == 0) begin
          checkOutput("miss_unexpected", 1, 0);
        end else begin
          mon_e = miss_q.pop_front();
          checkOutput("miss_cycle", cyc, mon_e.tag);
        end
      end
      while (lock_q.size() > 0 && lock_q[0].tag < cyc) begin
        mon_e = lock_q.pop_front();
        checkOutput("locked_change_missing", 0, 1);
      end
      if (locked !== prev_locked) begin
        if (lock_q.size() == 0) begin
          checkOutput("locked_change_unexpected", int'(locked), int'(prev_locked));
        end else begin
          mon_e = lock_q.pop_front();
          checkOutput("locked_change_cycle", cyc, mon_e.tag);
          checkOutput("locked_value", int'(locked), mon_e.val);
        end
      end
      prev_locked = locked;
      if (period_q.size() > 0 && period_q[0].tag == cyc) begin
        mon_e = period_q.pop_front();
        checkOutput("period_value", int'(period), mon_e.val);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind;
    int g;
    rst_n  = 1'b0;
    enable = 1'b1;
    ref_in = 1'b0;
    #2;
    checkOutput("reset_phase_rst", int'(phase_rst), 0);
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_period", int'(period), 0);
    checkOutput("reset_miss", int'(miss), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_mode   = M_ACQ;
    m_anchor = cyc + 1;
    last_c   = cyc;

    // Acquire and lock on a clean 1000-cycle reference.
    applyStimulus(50, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(PERIOD_C, 0, 0);

    // Window boundaries while locked, then two bad intervals unlock.
    applyStimulus(LO, 0, 0);
    applyStimulus(HI, 0, 0);
    applyStimulus(HI + 1, 0, 0);
    applyStimulus(HI + 1, 0, 0);

    // Relock, then drop one reference edge.
    for (int i = 0; i < 5; i++) applyStimulus(PERIOD_C, 0, 0);
    applyStimulus(2 * PERIOD_C, 0, 0);

    // Relock, then a one-cycle glitch 300 cycles after a locked edge.
    for (int i = 0; i < 5; i++) applyStimulus(PERIOD_C, 0, 0);
    applyStimulus(300, 1, 0);
    applyStimulus(700, 0, 0);

    // Relock, then drop enable in the same cycle as a rise, and re-enable.
    for (int i = 0; i < 5; i++) applyStimulus(PERIOD_C, 0, 0);
    applyStimulus(PERIOD_C, 0, 1);
    reEnable(30);
    for (int i = 0; i < 2; i++) applyStimulus(PERIOD_C, 0, 0);

    // Asynchronous reset in TRACK, then recovery and lock.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(PERIOD_C, 0, 0);

    // Randomised mix of good, bad, missing and glitch edges.
    for (int k = 0; k < 20; k++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        applyStimulus(LO + int'($urandom_range(0, HI - LO)), 0, 0);
      end else if (kind <= 7) begin
        if ($urandom_range(0, 1) == 1)
          applyStimulus(HI + 1 + int'($urandom_range(0, 40)), 0, 0);
        else
          applyStimulus(LO - 1 - int'($urandom_range(0, 40)), 0, 0);
      end else if (kind == 8) begin
        applyStimulus(2 * PERIOD_C - 5 + int'($urandom_range(0, 10)), 0, 0);
      end else begin
        g = int'($urandom_range(100, 900));
        applyStimulus(g, 1, 0);
        applyStimulus(PERIOD_C - g, 0, 0);
      end
    end

    // Let any trailing timeout play out, then confirm nothing is left over.
    modelGap(cyc + 3000);
    repeat (1200) @(posedge clk);
    #1;
    checkOutput("phase_q_drained", phase_q.size(), 0);
    checkOutput("miss_q_drained", miss_q.size(), 0);
    checkOutput("lock_q_drained", lock_q.size(), 0);
    checkOutput("period_q_drained", period_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
